// File: rtl/rob_retire_ctrl.sv
// ROB pointer/commit controller: tag allocation at dispatch, in-order retirement into the ARF,
// register-status release and mispredict flush. Optional stats counters under ROB_RETIRE_STATS_EN.
module rob_retire_ctrl #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned PTR_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              disp_req,
  output logic              disp_grant,
  output logic [PTR_W-1:0]  disp_tag,
  output logic              rob_full,
  output logic              rob_empty,
  output logic [PTR_W-1:0]  head_addr,
  input  logic              head_spec_valid,
  input  logic [DATA_W-1:0] head_spec_data,
  input  logic [4:0]        head_rd,
  input  logic              head_reg_write,
  input  logic              head_is_branch,
  input  logic              head_branch_taken,
  input  logic              head_pred_taken,
  input  logic              commit_stall,
  output logic              arf_wen,
  output logic [4:0]        arf_waddr,
  output logic [DATA_W-1:0] arf_wdata,
  output logic              rst_clr_en,
  output logic [PTR_W-1:0]  rst_clr_tag,
  output logic              flush
`ifdef ROB_RETIRE_STATS_EN
  ,
  output logic [31:0]       stat_retired,
  output logic [15:0]       stat_flushes
`endif
);

  localparam logic [PTR_W:0] PtrOne   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] DepthCnt = (PTR_W+1)'(DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]      head_q, head_d;
  logic [PTR_W:0]      tail_q, tail_d;
  logic [PTR_W:0]      count_d;
  logic                full_q, empty_q;
  logic                retire, mispredict, grant;
  logic                arf_wen_q, flush_q;
  logic [4:0]          arf_waddr_q;
  logic [DATA_W-1:0]   arf_wdata_q;
  logic [PTR_W-1:0]    clr_tag_q;

  always_comb begin
    retire     = ~empty_q & head_spec_valid & ~commit_stall & ~flush_q;
    mispredict = retire & head_is_branch & (head_branch_taken != head_pred_taken);
    // A mispredict rewrites tail this edge, so a concurrent request must not be granted.
    grant      = disp_req & ~full_q & ~flush_q & ~mispredict;

    head_d = head_q;
    tail_d = tail_q;
    if (retire) head_d = head_q + PtrOne;
    if (mispredict) begin
      tail_d = head_q + PtrOne;
    end else if (grant) begin
      tail_d = tail_q + PtrOne;
    end
    count_d = tail_d - head_d;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      arf_wen_q   <= 1'b0;
      arf_waddr_q <= '0;
      arf_wdata_q <= '0;
      clr_tag_q   <= '0;
      flush_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      full_q    <= (count_d == DepthCnt);
      empty_q   <= (head_d == tail_d);
      arf_wen_q <= retire & head_reg_write & (head_rd != 5'd0);
      flush_q   <= mispredict;
      if (retire) begin
        arf_waddr_q <= head_rd;
        arf_wdata_q <= head_spec_data;
        clr_tag_q   <= head_q[PTR_W-1:0];
      end
    end
  end

`ifdef ROB_RETIRE_STATS_EN
  logic [31:0] stat_retired_q;
  logic [15:0] stat_flushes_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_retired_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (retire)     stat_retired_q <= stat_retired_q + 32'd1;
      if (mispredict) stat_flushes_q <= stat_flushes_q + 16'd1;
    end
  end

  assign stat_retired = stat_retired_q;
  assign stat_flushes = stat_flushes_q;
`endif

  assign disp_grant  = grant;
  assign disp_tag    = tail_q[PTR_W-1:0];
  assign head_addr   = head_q[PTR_W-1:0];
  assign rob_full    = full_q;
  assign rob_empty   = empty_q;
  assign arf_wen     = arf_wen_q;
  assign arf_waddr   = arf_waddr_q;
  assign arf_wdata   = arf_wdata_q;
  assign rst_clr_en  = arf_wen_q;
  assign rst_clr_tag = clr_tag_q;
  assign flush       = flush_q;

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed bench for rob_retire_ctrl: fill/full, retire, x0, stall, mispredict, async reset.
module tb_rob_retire_ctrl;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        disp_req;
  logic        disp_grant;
  logic [5:0]  disp_tag;
  logic        rob_full;
  logic        rob_empty;
  logic [5:0]  head_addr;
  logic        head_spec_valid;
  logic [31:0] head_spec_data;
  logic [4:0]  head_rd;
  logic        head_reg_write;
  logic        head_is_branch;
  logic        head_branch_taken;
  logic        head_pred_taken;
  logic        commit_stall;
  logic        arf_wen;
  logic [4:0]  arf_waddr;
  logic [31:0] arf_wdata;
  logic        rst_clr_en;
  logic [5:0]  rst_clr_tag;
  logic        flush;
`ifdef ROB_RETIRE_STATS_EN
  logic [31:0] stat_retired;
  logic [15:0] stat_flushes;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rob_retire_ctrl #(.DEPTH(64), .PTR_W(6), .DATA_W(32)) u_dut (
    .clk               (clk),
    .i_rst_n           (i_rst_n),
    .disp_req          (disp_req),
    .disp_grant        (disp_grant),
    .disp_tag          (disp_tag),
    .rob_full          (rob_full),
    .rob_empty         (rob_empty),
    .head_addr         (head_addr),
    .head_spec_valid   (head_spec_valid),
    .head_spec_data    (head_spec_data),
    .head_rd           (head_rd),
    .head_reg_write    (head_reg_write),
    .head_is_branch    (head_is_branch),
    .head_branch_taken (head_branch_taken),
    .head_pred_taken   (head_pred_taken),
    .commit_stall      (commit_stall),
    .arf_wen           (arf_wen),
    .arf_waddr         (arf_waddr),
    .arf_wdata         (arf_wdata),
    .rst_clr_en        (rst_clr_en),
    .rst_clr_tag       (rst_clr_tag),
    .flush             (flush)
`ifdef ROB_RETIRE_STATS_EN
    ,
    .stat_retired      (stat_retired),
    .stat_flushes      (stat_flushes)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req          = 1'b0;
    head_spec_valid   = 1'b0;
    head_spec_data    = '0;
    head_rd           = '0;
    head_reg_write    = 1'b0;
    head_is_branch    = 1'b0;
    head_branch_taken = 1'b0;
    head_pred_taken   = 1'b0;
    commit_stall      = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_empty"},   64'(rob_empty),   64'd1);
    check_eq({pfx, "_full"},    64'(rob_full),    64'd0);
    check_eq({pfx, "_wen"},     64'(arf_wen),     64'd0);
    check_eq({pfx, "_waddr"},   64'(arf_waddr),   64'd0);
    check_eq({pfx, "_wdata"},   64'(arf_wdata),   64'd0);
    check_eq({pfx, "_clr_en"},  64'(rst_clr_en),  64'd0);
    check_eq({pfx, "_clr_tag"}, 64'(rst_clr_tag), 64'd0);
    check_eq({pfx, "_flush"},   64'(flush),       64'd0);
    check_eq({pfx, "_head"},    64'(head_addr),   64'd0);
    check_eq({pfx, "_tail"},    64'(disp_tag),    64'd0);
    check_eq({pfx, "_grant"},   64'(disp_grant),  64'd0);
`ifdef ROB_RETIRE_STATS_EN
    check_eq({pfx, "_stat_ret"}, 64'(stat_retired), 64'd0);
    check_eq({pfx, "_stat_fl"},  64'(stat_flushes), 64'd0);
`endif
  endtask

  initial begin
    idle_inputs();
    i_rst_n = 1'b0;
    #22;
    check_reset_state("rst");
    i_rst_n = 1'b1;
    tick();

    // Fill: tags 0..63 granted in order.
    for (int i = 0; i < 64; i++) begin
      disp_req = 1'b1;
      #1;
      check_eq($sformatf("fill_grant_tag%0d", i), {57'd0, disp_grant, disp_tag}, {57'd0, 1'b1, 6'(i)});
      tick();
    end
    check_eq("fill_full", 64'(rob_full), 64'd1);
    check_eq("fill_not_empty", 64'(rob_empty), 64'd0);
    #1;
    check_eq("req65_denied", 64'(disp_grant), 64'd0);

    // Full ROB, retire entry 0 with a concurrent request: retire happens, grant stays 0.
    head_spec_valid = 1'b1;
    head_rd         = 5'd5;
    head_reg_write  = 1'b1;
    head_spec_data  = 32'hDEADBEEF;
    #1;
    check_eq("full_retire_grant0", 64'(disp_grant), 64'd0);
    tick();
    check_eq("ret0_wen",     64'(arf_wen),     64'd1);
    check_eq("ret0_waddr",   64'(arf_waddr),   64'd5);
    check_eq("ret0_wdata",   64'(arf_wdata),   64'hDEADBEEF);
    check_eq("ret0_clr_en",  64'(rst_clr_en),  64'd1);
    check_eq("ret0_clr_tag", 64'(rst_clr_tag), 64'd0);
    check_eq("ret0_not_full", 64'(rob_full),   64'd0);
    check_eq("ret0_head",    64'(head_addr),   64'd1);

    // Tail has wrapped: next grant is tag 0.
    head_spec_valid = 1'b0;
    #1;
    check_eq("wrap_grant_tag0", {57'd0, disp_grant, disp_tag}, {57'd0, 1'b1, 6'd0});
    tick();
    disp_req = 1'b0;
    check_eq("refull", 64'(rob_full), 64'd1);
    check_eq("idle_wen0", 64'(arf_wen), 64'd0);

    // x0 destination: head advances, no ARF write, no status clear.
    head_spec_valid = 1'b1;
    head_rd         = 5'd0;
    head_reg_write  = 1'b1;
    head_spec_data  = 32'h0BADF00D;
    tick();
    check_eq("x0_wen",    64'(arf_wen),    64'd0);
    check_eq("x0_clr_en", 64'(rst_clr_en), 64'd0);
    check_eq("x0_head",   64'(head_addr),  64'd2);

    // Retire entry 2, then reset asynchronously while arf_wen is high.
    head_rd        = 5'd7;
    head_spec_data = 32'h12345678;
    tick();
    head_spec_valid = 1'b0;
    check_eq("pre_rst_wen",     64'(arf_wen),     64'd1);
    check_eq("pre_rst_clr_tag", 64'(rst_clr_tag), 64'd2);
    #1;
    i_rst_n = 1'b0;
    #1;
    idle_inputs();
    #1;
    check_reset_state("async_rst");
    #2;
    i_rst_n = 1'b1;
    tick();

    // Queue 10 entries.
    disp_req = 1'b1;
    repeat (10) tick();
    disp_req = 1'b0;
    check_eq("q10_tail", 64'(disp_tag), 64'd10);

    // Retire entries 0..2 with a stall cycle in the middle.
    for (int k = 0; k < 3; k++) begin
      head_spec_valid = 1'b1;
      head_rd         = 5'(k + 1);
      head_reg_write  = 1'b1;
      head_spec_data  = 32'h11 * (k + 1);
      tick();
      check_eq($sformatf("q_ret%0d_waddr", k), 64'(arf_waddr), 64'(k + 1));
      check_eq($sformatf("q_ret%0d_wdata", k), 64'(arf_wdata), 64'(32'h11 * (k + 1)));
      check_eq($sformatf("q_ret%0d_tag", k),   64'(rst_clr_tag), 64'(k));
      if (k == 1) begin
        commit_stall = 1'b1;
        tick();
        commit_stall = 1'b0;
        check_eq("stall_wen0", 64'(arf_wen),   64'd0);
        check_eq("stall_head", 64'(head_addr), 64'd2);
      end
    end

    // Head 3 is a mispredicted branch (taken=1, predicted=0).
    head_reg_write    = 1'b0;
    head_is_branch    = 1'b1;
    head_branch_taken = 1'b1;
    head_pred_taken   = 1'b0;
    tick();
    check_eq("mp_flush",    64'(flush),       64'd1);
    check_eq("mp_empty",    64'(rob_empty),   64'd1);
    check_eq("mp_clr_en",   64'(rst_clr_en),  64'd0);
    check_eq("mp_clr_tag",  64'(rst_clr_tag), 64'd3);
    check_eq("mp_head",     64'(head_addr),   64'd4);
    check_eq("mp_tail",     64'(disp_tag),    64'd4);
    disp_req = 1'b1;
    #1;
    check_eq("flush_no_grant", 64'(disp_grant), 64'd0);
    tick();
    check_eq("flush_one_cycle", 64'(flush),     64'd0);
    check_eq("flush_no_retire", 64'(head_addr), 64'd4);
    head_spec_valid = 1'b0;
    head_is_branch  = 1'b0;
    #1;
    check_eq("post_flush_grant_tag4", {57'd0, disp_grant, disp_tag}, {57'd0, 1'b1, 6'd4});
    tick();
    disp_req = 1'b0;
    check_eq("post_flush_not_empty", 64'(rob_empty), 64'd0);
`ifdef ROB_RETIRE_STATS_EN
    check_eq("stat_retired", 64'(stat_retired), 64'd4);
    check_eq("stat_flushes", 64'(stat_flushes), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
